// File: rtl/freq_gen_module.sv
// rtl/freq_gen_module.sv - programmable Bresenham square-wave generator with one-second tick
//
// Synthesises clk_out at an integer frequency (Hz) from clk_base.
// A 34-bit fractional accumulator makes the average output frequency exact.
//
// Ports:
//   clk_base  in   1   reference clock; all logic on posedge
//   rst_n     in   1   asynchronous active-low reset
//   enable    in   1   level; 1 = run generator
//   freq_set  in  32   requested output frequency in Hz
//   freq_wr   in   1   one-cycle write strobe for freq_set
//   clk_out   out  1   generated square wave (registered)
//   freq_cur  out 32   frequency currently applied
//   pend      out  1   a written value is waiting to be applied
//   err       out  1   sticky; last write rejected
//   sec_tick  out  1   one-cycle pulse every FREQ_BASE cycles
//   edge_cnt  out 32   rising edges of clk_out in the last tick window
//                      (only when FREQ_GEN_LOOPBACK_EN is defined)
//
// Optional feature macro: FREQ_GEN_LOOPBACK_EN
module freq_gen_module #(
    parameter int unsigned FREQ_BASE = 200_000_000
) (
    input  logic        clk_base,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] freq_set,
    input  logic        freq_wr,
    output logic        clk_out,
    output logic [31:0] freq_cur,
    output logic        pend,
    output logic        err,
`ifdef FREQ_GEN_LOOPBACK_EN
    output logic [31:0] edge_cnt,
`endif
    output logic        sec_tick
);

    localparam logic [33:0] BASE     = 34'(FREQ_BASE);
    localparam logic [31:0] HALF     = 32'(FREQ_BASE / 2);
    localparam logic [31:0] SEC_LAST = 32'(FREQ_BASE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [33:0] acc_q, acc_d;
    logic        clk_out_q, clk_out_d;
    logic [31:0] freq_cur_q, freq_cur_d;
    logic [31:0] freq_pend_q, freq_pend_d;
    logic        pend_q, pend_d;
    logic        err_q, err_d;
    logic [31:0] sec_cnt_q, sec_cnt_d;

    logic [33:0] step;
    logic [33:0] acc_sum;
    logic        toggle;
    logic        fall;
    logic        apply;

    // step = 2*freq_cur; freq_cur <= FREQ_BASE/2 keeps step <= FREQ_BASE,
    // so at most one toggle can occur per cycle.
    assign step    = {1'b0, freq_cur_q, 1'b0};
    assign acc_sum = acc_q + step;
    assign toggle  = (acc_sum >= BASE);
    assign fall    = toggle & clk_out_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        clk_out_d   = clk_out_q;
        freq_cur_d  = freq_cur_q;
        freq_pend_d = freq_pend_q;
        pend_d      = pend_q;
        err_d       = err_q;
        apply       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acc_d     = '0;
                clk_out_d = 1'b0;
                apply     = pend_q;
                if (enable && (freq_cur_q != 32'd0)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!enable && !clk_out_q) begin
                    // Output already low: stop at once without a new rise.
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end else begin
                    acc_d = toggle ? (acc_sum - BASE) : acc_sum;
                    if (toggle) begin
                        clk_out_d = ~clk_out_q;
                    end
                    // New frequencies take effect only on a falling edge so
                    // no high pulse is ever shortened.
                    if (fall && pend_q) begin
                        apply = 1'b1;
                        acc_d = '0;
                        if (freq_pend_q == 32'd0) begin
                            state_d = ST_IDLE;
                        end
                    end
                    if (!enable) begin
                        if (fall) begin
                            state_d = ST_IDLE;
                            acc_d   = '0;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end
                end
            end

            ST_STOP: begin
                // Let the current high phase finish at full length.
                acc_d = toggle ? (acc_sum - BASE) : acc_sum;
                if (toggle) begin
                    clk_out_d = ~clk_out_q;
                end
                if (fall) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                acc_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        if (apply) begin
            freq_cur_d = freq_pend_q;
            pend_d     = 1'b0;
        end

        // A write in the same cycle as an application becomes the new
        // pending value, since it is evaluated after the application.
        if (freq_wr) begin
            if (freq_set <= HALF) begin
                freq_pend_d = freq_set;
                pend_d      = 1'b1;
                err_d       = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign sec_cnt_d = (sec_cnt_q == SEC_LAST) ? 32'd0 : (sec_cnt_q + 32'd1);

    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            clk_out_q   <= 1'b0;
            freq_cur_q  <= '0;
            freq_pend_q <= '0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            sec_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            clk_out_q   <= clk_out_d;
            freq_cur_q  <= freq_cur_d;
            freq_pend_q <= freq_pend_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            sec_cnt_q   <= sec_cnt_d;
        end
    end

`ifdef FREQ_GEN_LOOPBACK_EN
    logic        rise;
    logic [31:0] rise_cnt_q, rise_cnt_d;
    logic [31:0] edge_cnt_q, edge_cnt_d;

    assign rise = clk_out_d & ~clk_out_q;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        rise_cnt_d = rise_cnt_q + {31'd0, rise};
        if (sec_tick) begin
            // Include a rise landing in the tick cycle itself.
            edge_cnt_d = rise_cnt_q + {31'd0, rise};
            rise_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt_q <= '0;
            edge_cnt_q <= '0;
        end else begin
            rise_cnt_q <= rise_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`endif

    assign clk_out  = clk_out_q;
    assign freq_cur = freq_cur_q;
    assign pend     = pend_q;
    assign err      = err_q;
    assign sec_tick = (sec_cnt_q == SEC_LAST);

endmodule
